// File: rtl/aes_mode_pkg.sv
// Shared types for the AES stream-mode controller: mode encodings, FSM states, block width.
// CTR decoding depends on the AES_CTR_MODE_EN build macro.
package aes_mode_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        MODE_ECB = 2'b00,
        MODE_CBC = 2'b01,
        MODE_CTR = 2'b10
    } aesMode_t;

    typedef enum logic [2:0] {
        IDLE,
        KEY_SKIP,
        KEY_WAIT,
        READY,
        BLK_SKIP,
        BLK_WAIT
    } ctrlState_t;

    // Reserved encodings, and CTR when it is not built in, fall back to ECB.
    function automatic aesMode_t decodeMode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_CBC;
`ifdef AES_CTR_MODE_EN
            2'b10:   return MODE_CTR;
`endif
            default: return MODE_ECB;
        endcase
    endfunction

endpackage

// File: rtl/aes_mode_fifo.sv
// Synchronous first-word-fall-through FIFO buffering input blocks for the AES mode controller.
module aes_mode_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wrData,
    input  logic             pop,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    // Extra pointer bit tells a wrapped-full FIFO apart from an empty one.
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr[AW-1:0]];

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/aes_mode_ctrl.sv
// Stream controller sequencing an AES-128 core (init/next/ready) in ECB, CBC-encrypt or CTR mode.
// CTR mode and its counter exist only when AES_CTR_MODE_EN is defined; otherwise mode 10 runs as ECB.
module aes_mode_ctrl
    import aes_mode_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CTR_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [AES_BLK_W-1:0] key,
    input  logic [AES_BLK_W-1:0] iv,
    input  logic                 key_load,
    output logic                 cfg_ready,
    input  logic [AES_BLK_W-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [AES_BLK_W-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 core_init,
    output logic                 core_next,
    output logic [AES_BLK_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_block,
    input  logic                 core_ready,
    input  logic [AES_BLK_W-1:0] core_result
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadDepth
        $error("aes_mode_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end
    if ((CTR_W < 1) || (CTR_W >= AES_BLK_W)) begin : gBadCtrW
        $error("aes_mode_ctrl: CTR_W must be between 1 and %0d", AES_BLK_W - 1);
    end

    ctrlState_t           state;
    ctrlState_t           stateNext;
    aesMode_t             modeReg;
    logic [AES_BLK_W-1:0] chainReg;
    logic [AES_BLK_W-1:0] fifoHead;
    logic [AES_BLK_W-1:0] blockIn;
    logic [AES_BLK_W-1:0] blockOut;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 rstDone;
    logic                 acceptKey;
    logic                 startBlk;
    logic                 finishBlk;

    aes_mode_fifo #(
        .WIDTH (AES_BLK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (din_valid && din_ready),
        .wrData (din),
        .pop    (startBlk),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // Handshake outputs stay low until the first clock after reset is released.
    assign din_ready = rstDone && !fifoFull;
    assign cfg_ready = rstDone && ((state == IDLE) ||
                                   ((state == READY) && fifoEmpty && !dout_valid));
    assign busy      = ((state != IDLE) && (state != READY)) || !fifoEmpty || dout_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        acceptKey = 1'b0;
        startBlk  = 1'b0;
        finishBlk = 1'b0;
        case (state)
            IDLE: begin
                if (key_load && cfg_ready) begin
                    acceptKey = 1'b1;
                    stateNext = KEY_SKIP;
                end
            end
            KEY_SKIP: stateNext = KEY_WAIT;
            KEY_WAIT: if (core_ready) stateNext = READY;
            READY: begin
                if (key_load && cfg_ready) begin
                    acceptKey = 1'b1;
                    stateNext = KEY_SKIP;
                end else if (!fifoEmpty && !dout_valid) begin
                    startBlk  = 1'b1;
                    stateNext = BLK_SKIP;
                end
            end
            BLK_SKIP: stateNext = BLK_WAIT;
            BLK_WAIT: begin
                if (core_ready) begin
                    finishBlk = 1'b1;
                    stateNext = READY;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef AES_CTR_MODE_EN
    logic [AES_BLK_W-1:0] ctrReg;
    logic [AES_BLK_W-1:0] poppedDin;

    // Only the low CTR_W bits count; they wrap without carrying into the fixed upper field.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrReg    <= '0;
            poppedDin <= '0;
        end else begin
            if (acceptKey) ctrReg <= iv;
            else if (finishBlk && (modeReg == MODE_CTR))
                ctrReg[CTR_W-1:0] <= ctrReg[CTR_W-1:0] + CTR_W'(1);
            if (startBlk) poppedDin <= fifoHead;
        end
    end
`endif

    always_comb begin
        blockIn  = fifoHead;
        blockOut = core_result;
        if (modeReg == MODE_CBC) blockIn = fifoHead ^ chainReg;
`ifdef AES_CTR_MODE_EN
        if (modeReg == MODE_CTR) begin
            blockIn  = ctrReg;
            blockOut = poppedDin ^ core_result;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rstDone    <= 1'b0;
            modeReg    <= MODE_ECB;
            chainReg   <= '0;
            core_init  <= 1'b0;
            core_next  <= 1'b0;
            core_key   <= '0;
            core_block <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            rstDone   <= 1'b1;
            core_init <= acceptKey;
            core_next <= startBlk;
            if (acceptKey) begin
                core_key <= key;
                modeReg  <= decodeMode(mode);
                chainReg <= iv;
            end
            if (startBlk) core_block <= blockIn;
            if (finishBlk) begin
                dout       <= blockOut;
                dout_valid <= 1'b1;
                if (modeReg == MODE_CBC) chainReg <= core_result;
            end else if (dout_valid && dout_ready) begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl driving a behavioural AES-128 core with NIST SP800-38A vectors.
// Expectations follow the AES_CTR_MODE_EN build macro (mode 10 acts as ECB when it is undefined).
module tb_aes_mode_ctrl;
    import aes_mode_pkg::*;

    localparam int KEY_LAT = 5;
    localparam int BLK_LAT = 6;
    localparam int DEPTH   = 4;
    localparam int BOUND   = 200;

    localparam logic [127:0] K      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3     = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4     = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] P5     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_ECB = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] C2_ECB = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] IV_CBC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CBC = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2_CBC = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] IV_CTR = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] C1_CTR = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] C2_CTR = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] IV_WRAP = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
    localparam logic [127:0] CTR_WRAPPED = 128'hf0f1f2f3f4f5f6f7f8f9fafb00000000;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mode;
    logic [127:0] key;
    logic [127:0] iv;
    logic         key_load;
    logic         cfg_ready;
    logic [127:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         core_init;
    logic         core_next;
    logic [127:0] core_key;
    logic [127:0] core_block;
    logic         core_ready;
    logic [127:0] core_result;

    int passCount = 0;
    int checkCount = 0;
    logic [127:0] nextLog[$];

    aes_mode_ctrl #(.FIFO_DEPTH(DEPTH), .CTR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .key         (key),
        .iv          (iv),
        .key_load    (key_load),
        .cfg_ready   (cfg_ready),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .busy        (busy),
        .core_init   (core_init),
        .core_next   (core_next),
        .core_key    (core_key),
        .core_block  (core_block),
        .core_ready  (core_ready),
        .core_result (core_result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aesEncrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i/4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            // byte i sits at row i%4, column i/4; row r rotates left by r columns
            for (int i = 0; i < 16; i++) t[i] = sb(s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]);
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
        return ct;
    endfunction

    // Behavioural core: ready drops the edge after init/next, returns after a fixed latency.
    logic [127:0] modelKey;
    logic [127:0] pending;
    int           coreCnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_ready  <= 1'b1;
            core_result <= '0;
            modelKey    <= '0;
            pending     <= '0;
            coreCnt     <= 0;
        end else if (core_init) begin
            core_ready <= 1'b0;
            coreCnt    <= KEY_LAT;
            modelKey   <= core_key;
        end else if (core_next) begin
            core_ready <= 1'b0;
            coreCnt    <= BLK_LAT;
            pending    <= aesEncrypt(modelKey, core_block);
        end else if (coreCnt > 0) begin
            coreCnt <= coreCnt - 1;
            if (coreCnt == 1) begin
                core_ready  <= 1'b1;
                core_result <= pending;
            end
        end
    end

    always @(negedge clk) begin
        if (core_next) nextLog.push_back(core_block);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else passCount++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        #2 reset = 1'b0;
        #1;
        check("rst ctrl outs", {cfg_ready, din_ready, dout_valid, busy, core_init, core_next}, 0);
        check("rst dout", dout, 0);
        check("rst core_key", core_key, 0);
        check("rst core_block", core_block, 0);
        check("rst state", dut.state, IDLE);
        step();
        step();
        reset = 1'b1;
        step();
        check("cfg_ready after rst", cfg_ready, 1);
    endtask

    task automatic loadKey(input logic [127:0] k, input logic [127:0] v, input logic [1:0] m);
        int n = 0;
        while (!cfg_ready && n < BOUND) begin step(); n++; end
        check("cfg_ready before load", cfg_ready, 1);
        key = k; iv = v; mode = m; key_load = 1'b1;
        step();
        key_load = 1'b0;
        n = 0;
        while (busy && n < BOUND) begin step(); n++; end
        check("key expansion done", busy, 0);
    endtask

    task automatic pushBlk(input logic [127:0] d);
        int n = 0;
        din = d; din_valid = 1'b1;
        while (!din_ready && n < BOUND) begin step(); n++; end
        check("push accepted", din_ready, 1);
        step();
        din_valid = 1'b0;
    endtask

    task automatic popBlk(input string tag, input logic [127:0] exp);
        int n = 0;
        while (!dout_valid && n < BOUND) begin step(); n++; end
        check({tag, " valid"}, dout_valid, 1);
        check(tag, dout, exp);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
    endtask

    task automatic waitBlkWait();
        int n = 0;
        while (!core_next && n < BOUND) begin step(); n++; end
        check("core_next seen", core_next, 1);
        step();
        check("in BLK_WAIT", dut.state, BLK_WAIT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] bp [5];
        logic [127:0] exp1, exp2, heldVal;
        int n, bad;
        reset = 1'b0; mode = 2'b00; key = '0; iv = '0; key_load = 1'b0;
        din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        applyReset();
        check("din_ready after rst", din_ready, 1);

        // ECB plus end-to-end latency
        loadKey(K, '0, 2'b00);
        check("core_key", core_key, K);
        pushBlk(P1);
        n = 0;
        while (!dout_valid && n < BOUND) begin step(); n++; end
        check("ecb latency", n, BLK_LAT + 3);
        popBlk("ecb p1", C1_ECB);
        check("dout cleared", {dout_valid, dout}, 0);

        // CBC chaining across two blocks
        loadKey(K, IV_CBC, 2'b01);
        pushBlk(P1);
        pushBlk(P2);
        popBlk("cbc p1", C1_CBC);
        popBlk("cbc p2", C2_CBC);

        // CTR with counter increment between blocks
`ifdef AES_CTR_MODE_EN
        exp1 = C1_CTR; exp2 = C2_CTR;
`else
        exp1 = C1_ECB; exp2 = C2_ECB;
`endif
        loadKey(K, IV_CTR, 2'b10);
        pushBlk(P1);
        popBlk("ctr p1", exp1);
        pushBlk(P2);
        popBlk("ctr p2", exp2);

        // CTR low-word wrap: no carry into the upper 96 bits
        nextLog.delete();
        loadKey(K, IV_WRAP, 2'b10);
        pushBlk(P1);
        pushBlk(P2);
`ifdef AES_CTR_MODE_EN
        popBlk("wrap p1", P1 ^ aesEncrypt(K, IV_WRAP));
        popBlk("wrap p2", P2 ^ aesEncrypt(K, CTR_WRAPPED));
        exp1 = IV_WRAP; exp2 = CTR_WRAPPED;
`else
        popBlk("wrap p1", aesEncrypt(K, P1));
        popBlk("wrap p2", aesEncrypt(K, P2));
        exp1 = P1; exp2 = P2;
`endif
        check("wrap next count", nextLog.size(), 2);
        if (nextLog.size() == 2) begin
            check("wrap block0", nextLog[0], exp1);
            check("wrap block1", nextLog[1], exp2);
        end

        // reserved mode 11 runs as ECB
        loadKey(K, IV_CBC, 2'b11);
        pushBlk(P2);
        popBlk("mode11 p2", C2_ECB);

        // backpressure: FIFO fills, dout holds, nothing lost or duplicated
        bp[0] = P1; bp[1] = P2; bp[2] = P3; bp[3] = P4; bp[4] = P5;
        loadKey(K, '0, 2'b00);
        for (int i = 0; i < DEPTH + 1; i++) pushBlk(bp[i]);
        check("full din_ready", din_ready, 0);
        din = 128'hdeadbeef; din_valid = 1'b1;
        repeat (3) step();
        check("still full", din_ready, 0);
        din_valid = 1'b0;
        n = 0;
        while (!dout_valid && n < BOUND) begin step(); n++; end
        heldVal = aesEncrypt(K, bp[0]);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!dout_valid || dout !== heldVal) bad++;
            step();
        end
        check("dout held", bad, 0);
        for (int i = 0; i < DEPTH + 1; i++) popBlk($sformatf("bp blk%0d", i), aesEncrypt(K, bp[i]));
        repeat (BLK_LAT + 10) step();
        check("no extra output", {dout_valid, busy}, 0);

        // asynchronous reset while the core is working on a block
        loadKey(K, '0, 2'b00);
        pushBlk(P1);
        waitBlkWait();
        applyReset();
        loadKey(K, '0, 2'b00);
        pushBlk(P1);
        popBlk("post-reset ecb", C1_ECB);

        // key_load during BLK_WAIT must be ignored
        pushBlk(P1);
        waitBlkWait();
        key = K2; iv = 128'h55; mode = 2'b01; key_load = 1'b1;
        check("cfg_ready in BLK_WAIT", cfg_ready, 0);
        step();
        key_load = 1'b0;
        check("ignored key_load state", dut.state, BLK_WAIT);
        check("core_key kept", core_key, K);
        popBlk("ignored ld p1", C1_ECB);
        pushBlk(P2);
        popBlk("ignored ld p2", C2_ECB);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
